// File: rtl/button_cmd_encoder.sv
// Debounced N-channel button front end: synchronise, debounce, priority-encode rising edges
// into a registered command code with level, latched or pulse release behaviour.
module button_cmd_encoder #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 4,
  parameter int CODE_W          = 32,
  parameter int MODE            = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_BTN-1:0]  btn_in,
  input  logic              clear,
  output logic [CODE_W-1:0] cmd_code,
  output logic              cmd_valid,
  output logic              cmd_new,
  output logic [N_BTN-1:0]  btn_clean
);

  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;

  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic [HOLD_W-1:0] hold_inc_sat(input logic [HOLD_W-1:0] h);
    return (h >= HOLD_SAT) ? HOLD_SAT : h + HOLD_W'(1);
  endfunction

  logic [N_BTN-1:0]  sync1_q, sync2_q;
  logic [CNT_W-1:0]  cnt_q [N_BTN];
  logic [CNT_W-1:0]  cnt_d [N_BTN];
  logic [N_BTN-1:0]  clean_q, clean_d, clean_prev_q;
  logic [N_BTN-1:0]  rise;
  logic              any_rise;
  logic [IDX_W-1:0]  win_idx;
  logic              clr_hit;
  logic              drop_act;

  state_t            state_q;
  logic [CODE_W-1:0] code_q;
  logic              valid_q;
  logic              new_q;
  logic [HOLD_W-1:0] hold_q;
  logic [IDX_W-1:0]  act_idx_q;

  // Stage: two-flop synchroniser on the raw asynchronous inputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Stage: per-channel debounce; the clean level only follows a mismatch held for the full period
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i]   = cnt_q[i];
      clean_d[i] = clean_q[i];
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
      clean_q      <= '0;
      clean_prev_q <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
      clean_q      <= clean_d;
      clean_prev_q <= clean_q;
    end
  end

  // Stage: rising-edge detect and lowest-index-wins priority encode
  assign rise     = clean_q & ~clean_prev_q;
  assign any_rise = |rise;

  always_comb begin
    win_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) win_idx = IDX_W'(i);
    end
  end

  // In latched mode clear also suppresses a coincident rise, so clear always leaves the output at 0
  assign clr_hit = (MODE == 1) && clear;

  always_comb begin
    drop_act = 1'b0;
    if (MODE == 0) begin
      drop_act = !clean_q[act_idx_q] && (hold_q >= HOLD_LAST);
    end else if (MODE == 2) begin
      drop_act = (hold_q == HOLD_LAST);
    end
  end

  // Stage: command FSM with registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      code_q    <= '0;
      valid_q   <= 1'b0;
      new_q     <= 1'b0;
      hold_q    <= '0;
      act_idx_q <= '0;
    end else begin
      new_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_rise && !clr_hit) begin
            state_q   <= ACTIVE;
            code_q    <= CODE_W'(win_idx) + CODE_W'(1);
            valid_q   <= 1'b1;
            new_q     <= 1'b1;
            hold_q    <= '0;
            act_idx_q <= win_idx;
          end
        end
        ACTIVE: begin
          if (clr_hit) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
          end else if (any_rise) begin
            code_q    <= CODE_W'(win_idx) + CODE_W'(1);
            valid_q   <= 1'b1;
            new_q     <= 1'b1;
            hold_q    <= '0;
            act_idx_q <= win_idx;
          end else if (drop_act) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            hold_q  <= '0;
          end else begin
            hold_q <= hold_inc_sat(hold_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_code  = code_q;
  assign cmd_valid = valid_q;
  assign cmd_new   = new_q;
  assign btn_clean = clean_q;

endmodule

// File: tb/tb_button_cmd_encoder.sv
// Scoreboard bench: three encoders (level, latched, pulse) share one stimulus stream and are
// checked against an event-level reference model.
module tb_button_cmd_encoder;
  localparam int N    = 5;
  localparam int DEB  = 4;
  localparam int HOLD = 3;
  localparam int CW   = 32;
  localparam int K_LOAD  = 0;
  localparam int K_IDLE  = 1;
  localparam int K_CLEAN = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic [N-1:0]  btn_in = '0;
  logic [CW-1:0] code0, code1, code2;
  logic          v0, v1, v2, n0, n1, n2;
  logic [N-1:0]  c0, c1, c2;

  button_cmd_encoder #(.N_BTN(N), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CODE_W(CW), .MODE(0)) u_lvl (
    .clock(clock), .reset_n(reset_n), .btn_in(btn_in), .clear(clear),
    .cmd_code(code0), .cmd_valid(v0), .cmd_new(n0), .btn_clean(c0));
  button_cmd_encoder #(.N_BTN(N), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CODE_W(CW), .MODE(1)) u_lat (
    .clock(clock), .reset_n(reset_n), .btn_in(btn_in), .clear(clear),
    .cmd_code(code1), .cmd_valid(v1), .cmd_new(n1), .btn_clean(c1));
  button_cmd_encoder #(.N_BTN(N), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CODE_W(CW), .MODE(2)) u_pls (
    .clock(clock), .reset_n(reset_n), .btn_in(btn_in), .clear(clear),
    .cmd_code(code2), .cmd_valid(v2), .cmd_new(n2), .btn_clean(c2));

  typedef struct {int kind; int cyc; int val;} ev_t;
  ev_t q0[$], q1[$], q2[$];

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;
  bit mon_en = 1'b0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push(int m, int kind, int val);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.val = val;
    if (m == 0) q0.push_back(e);
    else if (m == 1) q1.push_back(e);
    else q2.push_back(e);
  endfunction

  // Reference model: event-level view of the behaviour, evaluated once per clock edge
  bit [N-1:0] raw_1ago, raw_2ago, last_s, clean_m, prev_m, s_m, rise_m, nclean_m;
  int run_len [N];
  bit act_m [3];
  int t0_m [3];
  int idx_m [3];
  int win_m;
  bit ends;

  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      for (int m = 0; m < 3; m++) begin
        if (act_m[m]) push(m, K_IDLE, 0);
        act_m[m] = 1'b0;
      end
      if (clean_m != '0) for (int m = 0; m < 3; m++) push(m, K_CLEAN, 0);
      clean_m = '0; prev_m = '0; raw_1ago = '0; raw_2ago = '0; last_s = '0;
      for (int i = 0; i < N; i++) run_len[i] = 0;
    end else begin
      s_m = raw_2ago;
      raw_2ago = raw_1ago;
      raw_1ago = btn_in;
      rise_m = clean_m & ~prev_m;
      win_m = -1;
      for (int i = 0; i < N; i++) if (rise_m[i] && win_m < 0) win_m = i;
      for (int m = 0; m < 3; m++) begin
        if (m == 1 && clear) begin
          if (act_m[m]) push(m, K_IDLE, 0);
          act_m[m] = 1'b0;
        end else if (win_m >= 0) begin
          act_m[m] = 1'b1; idx_m[m] = win_m; t0_m[m] = cyc;
          push(m, K_LOAD, win_m + 1);
        end else if (act_m[m]) begin
          ends = (m == 0 && !clean_m[idx_m[m]] && (cyc - t0_m[m]) >= HOLD) ||
                 (m == 2 && (cyc - t0_m[m]) >= HOLD);
          if (ends) begin
            act_m[m] = 1'b0;
            push(m, K_IDLE, 0);
          end
        end
      end
      prev_m = clean_m;
      nclean_m = clean_m;
      for (int i = 0; i < N; i++) begin
        if (s_m[i] == last_s[i]) run_len[i]++;
        else begin run_len[i] = 1; last_s[i] = s_m[i]; end
        if (s_m[i] != clean_m[i] && run_len[i] >= DEB) nclean_m[i] = s_m[i];
      end
      if (nclean_m != clean_m) for (int m = 0; m < 3; m++) push(m, K_CLEAN, int'(nclean_m));
      clean_m = nclean_m;
    end
  end

  // Monitor: pop an expected event whenever a DUT presents one
  bit         pv [3];
  bit [N-1:0] pc [3];

  task automatic expect_ev(int m, string name, int kind, int val);
    ev_t e;
    bit empty;
    empty = 1'b0;
    if (m == 0) begin if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front(); end
    else if (m == 1) begin if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front(); end
    else begin if (q2.size() == 0) empty = 1'b1; else e = q2.pop_front(); end
    n_chk++;
    if (empty)
      $display("FAIL %s dut%0d: unexpected event val %0d at cycle %0d, none expected", name, m, val, cyc);
    else if (e.kind == kind && e.cyc == cyc && e.val == val)
      n_pass++;
    else
      $display("FAIL %s dut%0d: got kind %0d val %0d at cycle %0d, expected kind %0d val %0d at cycle %0d",
               name, m, kind, val, cyc, e.kind, e.val, e.cyc);
  endtask

  task automatic monitor_one(int m, int code, bit v, bit n, bit [N-1:0] c);
    if (n) begin
      expect_ev(m, "cmd_new", K_LOAD, code);
      chk("valid_with_new", int'(v), 1);
    end
    if (!pv[m] && v && !n) chk("valid_rise_without_new", int'(n), 1);
    if (pv[m] && !v) expect_ev(m, "valid_fall", K_IDLE, code);
    if (c != pc[m]) expect_ev(m, "btn_clean", K_CLEAN, int'(c));
    pv[m] = v;
    pc[m] = c;
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      monitor_one(0, int'(code0), v0, n0, c0);
      monitor_one(1, int'(code1), v1, n1, c1);
      monitor_one(2, int'(code2), v2, n2, c2);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_clear();
    clear = 1'b1; tick(1); clear = 1'b0; tick(2);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_code_lvl"}, int'(code0), 0);
    chk({tag, "_code_lat"}, int'(code1), 0);
    chk({tag, "_code_pls"}, int'(code2), 0);
    chk({tag, "_valid"}, int'(v0) + int'(v1) + int'(v2), 0);
    chk({tag, "_new"}, int'(n0) + int'(n1) + int'(n2), 0);
    chk({tag, "_clean"}, int'(c0) + int'(c1) + int'(c2), 0);
  endtask

  int p, r;

  initial begin
    tick(3);
    chk_zero("reset");
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Bouncy press of button 2, settling high
    for (int k = 0; k < 6; k++) begin
      btn_in[2] = ~btn_in[2];
      tick(2);
    end
    btn_in[2] = 1'b1;
    p = cyc;
    for (int k = 0; k < 20 && !c0[2]; k++) tick(1);
    chk("bounce_clean_latency", cyc - p, 6);
    tick(1);
    chk("bounce_cmd_new", int'(n0), 1);
    chk("bounce_code", int'(code0), 3);
    btn_in = '0; tick(12);
    chk("latched_persists", int'(code1), 3);
    pulse_clear();
    chk("latched_cleared", int'(code1), 0);

    // Simultaneous press of buttons 1 and 3
    btn_in[1] = 1'b1; btn_in[3] = 1'b1; tick(10);
    chk("simul_code", int'(code0), 2);
    btn_in[1] = 1'b0; tick(10);
    chk("simul_release_code", int'(code0), 0);
    chk("simul_release_valid", int'(v0), 0);
    btn_in = '0; tick(10); pulse_clear();

    // Shortest possible press, then a long press, on button 0
    btn_in[0] = 1'b1; tick(DEB); btn_in[0] = 1'b0; tick(15);
    btn_in[0] = 1'b1; tick(20); btn_in[0] = 1'b0; tick(15);
    pulse_clear();

    // Latched mode: replacement, clear, and clear coinciding with a rise
    btn_in[4] = 1'b1; tick(10); btn_in[4] = 1'b0; tick(10);
    chk("latched_code5", int'(code1), 5);
    btn_in[0] = 1'b1; tick(10);
    chk("latched_code1", int'(code1), 1);
    btn_in[0] = 1'b0; tick(10);
    pulse_clear();
    chk("latched_clear", int'(code1), 0);
    btn_in[2] = 1'b1;
    tick(6);
    clear = 1'b1; tick(1); clear = 1'b0; tick(3);
    chk("clear_beats_rise_code", int'(code1), 0);
    chk("clear_beats_rise_valid", int'(v1), 0);
    chk("rise_loads_pulse_mode", int'(code2), 0);
    btn_in = '0; tick(12);

    // Long hold in pulse mode
    btn_in[1] = 1'b1; tick(50); btn_in[1] = 1'b0; tick(15);
    pulse_clear();

    // Reset while active with button 2 held
    btn_in[2] = 1'b1; tick(10);
    chk("pre_reset_active", int'(code0), 3);
    reset_n = 1'b0; tick(1);
    chk_zero("midreset");
    reset_n = 1'b1;
    r = cyc;
    for (int k = 0; k < 20 && !n0; k++) tick(1);
    chk("post_reset_reload_latency", cyc - r, 7);
    chk("post_reset_code", int'(code0), 3);
    btn_in = '0; tick(12); pulse_clear();

    // Randomised presses, overlaps and clears
    for (int it = 0; it < 60; it++) begin
      btn_in = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 2) == 0) btn_in = '0;
      for (int k = 0; k < int'($urandom_range(1, 14)); k++) begin
        clear = ($urandom_range(0, 19) == 0);
        tick(1);
      end
    end
    btn_in = '0; clear = 1'b0; tick(20);
    pulse_clear(); tick(5);

    chk("lvl_queue_drained", q0.size(), 0);
    chk("lat_queue_drained", q1.size(), 0);
    chk("pls_queue_drained", q2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
